// File: rtl/flit_link_buffer_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the mesh NoC link logic.
//   FW_DEF  default flit width
//   B_DEF   default link buffer depth (also the node input depth)
//   FTW     width of the flit type field, carried in the top bits of a flit
//   FT_LSB  bit position of the flit type field
//   flit_t  packed view of a default-width flit (type field + payload)
// ---------------------------------------------------------------------------
package noc_pkg;

    localparam int FW_DEF = 59;
    localparam int B_DEF  = 4;
    localparam int FTW    = 3;
    localparam int FT_LSB = FW_DEF - FTW;

    typedef enum logic [FTW-1:0] {
        FT_HEAD   = 3'd0,
        FT_BODY   = 3'd1,
        FT_TAIL   = 3'd2,
        FT_SINGLE = 3'd3
    } flit_type_e;

    typedef struct packed {
        flit_type_e          ftype;
        logic [FT_LSB-1:0]   payload;
    } flit_t;

endpackage

// File: rtl/flit_link_buffer_fifo.sv
// ---------------------------------------------------------------------------
// flit_fifo
// Synchronous FIFO holding flits between the router and the node.
// A write while full is still accepted when a read happens on the same edge,
// because the read frees the slot. Pointers wrap modulo DEPTH, so DEPTH does
// not have to be a power of two. rd_data shows the head entry combinationally.
//   clk, rst_n  clock, asynchronous active-low reset (pointers/count only)
//   wr_en       write request, wr_data the entry to store
//   rd_en       pop the head entry (ignored while empty)
//   rd_data     current head entry
//   full/empty  status flags derived from count
//   count       number of entries held
// ---------------------------------------------------------------------------
module flit_fifo
    import noc_pkg::*;
#(
    parameter  int DEPTH = B_DEF,
    parameter  int WIDTH = FW_DEF,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = mem[rd_ptr];

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/flit_link_buffer.sv
// ---------------------------------------------------------------------------
// flit_link_buffer
// Credit-based link stage between a mesh-router output port and a node input.
// Flits from the router are buffered; the head flit is forwarded only while
// the node has advertised credits, and every forwarded flit returns one
// credit upstream so both hops stay lossless.
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   flit_in_wr   upstream flit valid, flit_in the flit
//   credit_out   one-cycle pulse per buffer slot freed (to upstream)
//   flit_out_wr  downstream flit valid, flit_out the registered flit
//   credit_in    one-cycle pulse per slot the node freed
//   occupancy    flits currently held in the buffer
//   ovf_err      sticky: write arrived while the buffer was full
//   credit_err   sticky: credit_in arrived with the counter already at B
// ---------------------------------------------------------------------------
module flit_link_buffer
    import noc_pkg::*;
#(
    parameter  int B    = B_DEF,
    parameter  int FW   = FW_DEF,
    localparam int CNTW = $clog2(B + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flit_in_wr,
    input  logic [FW-1:0]   flit_in,
    output logic            credit_out,
    output logic            flit_out_wr,
    output logic [FW-1:0]   flit_out,
    input  logic            credit_in,
    output logic [CNTW-1:0] occupancy,
    output logic            ovf_err,
    output logic            credit_err
);

    logic [FW-1:0]   head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CNTW-1:0] fifo_count;

    logic [CNTW-1:0] credit_p0;
    logic            pop_p0;
    logic            push_blocked;
    logic            credit_overrun;
    logic            ovf_err_q;
    logic            credit_err_q;

    logic            vld_p1;
    logic            crd_p1;
    logic [FW-1:0]   flit_p1;

    // A pop spends one credit, a returned credit adds one; both cancel out.
    // The counter saturates at B so a spurious credit cannot inflate it.
    function automatic logic [CNTW-1:0] credit_next(input logic [CNTW-1:0] cnt,
                                                    input logic            dec,
                                                    input logic            inc);
        logic [CNTW-1:0] nxt;
        nxt = cnt;
        if (dec && !inc) begin
            nxt = cnt - CNTW'(1);
        end else if (!dec && inc && (cnt != CNTW'(B))) begin
            nxt = cnt + CNTW'(1);
        end
        return nxt;
    endfunction

    // ---- stage p0: buffer, send decision, credit accounting ----
    flit_fifo #(
        .DEPTH (B),
        .WIDTH (FW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (flit_in_wr),
        .wr_data (flit_in),
        .rd_en   (pop_p0),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // The send decision looks at the counter before this edge's update, and
    // at the FIFO before this edge's write, so an empty FIFO never bypasses.
    assign pop_p0         = !fifo_empty && (credit_p0 != '0);
    assign push_blocked   = flit_in_wr && fifo_full && !pop_p0;
    assign credit_overrun = credit_in && !pop_p0 && (credit_p0 == CNTW'(B));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_p0    <= CNTW'(B);
            ovf_err_q    <= 1'b0;
            credit_err_q <= 1'b0;
        end else begin
            credit_p0 <= credit_next(credit_p0, pop_p0, credit_in);
            if (push_blocked) begin
                ovf_err_q <= 1'b1;
            end
            if (credit_overrun) begin
                credit_err_q <= 1'b1;
            end
        end
    end

    // ---- stage p1: registered flit, valid and returned credit ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            crd_p1  <= 1'b0;
            flit_p1 <= '0;
        end else begin
            vld_p1 <= pop_p0;
            crd_p1 <= pop_p0;
            if (pop_p0) begin
                flit_p1 <= head;
            end
        end
    end

    assign flit_out_wr = vld_p1;
    assign flit_out    = flit_p1;
    assign credit_out  = crd_p1;
    assign occupancy   = fifo_count;
    assign ovf_err     = ovf_err_q;
    assign credit_err  = credit_err_q;

endmodule

// File: tb/tb_flit_link_buffer.sv
// ---------------------------------------------------------------------------
// tb_flit_link_buffer
// Drives flit_link_buffer with directed and random traffic and compares every
// cycle against a queue-based reference of the link behaviour.
// ---------------------------------------------------------------------------
module tb_flit_link_buffer;

    localparam int B    = 4;
    localparam int FW   = 59;
    localparam int CNTW = $clog2(B + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flit_in_wr = 1'b0;
    logic [FW-1:0]   flit_in = '0;
    logic            credit_in = 1'b0;
    logic            credit_out;
    logic            flit_out_wr;
    logic [FW-1:0]   flit_out;
    logic [CNTW-1:0] occupancy;
    logic            ovf_err;
    logic            credit_err;

    int errors = 0;
    int checks = 0;

    // Reference state: buffered flits, node credits, expected outputs.
    logic [FW-1:0] mq[$];
    int            mcred;
    logic          exp_wr, exp_cout, exp_ovf, exp_cerr;
    logic [FW-1:0] exp_flit;
    int            exp_occ;

    always #5 clk = ~clk;

    flit_link_buffer #(.B(B), .FW(FW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flit_in_wr  (flit_in_wr),
        .flit_in     (flit_in),
        .credit_out  (credit_out),
        .flit_out_wr (flit_out_wr),
        .flit_out    (flit_out),
        .credit_in   (credit_in),
        .occupancy   (occupancy),
        .ovf_err     (ovf_err),
        .credit_err  (credit_err)
    );

    task automatic model_reset();
        mq.delete();
        mcred    = B;
        exp_wr   = 1'b0;
        exp_cout = 1'b0;
        exp_ovf  = 1'b0;
        exp_cerr = 1'b0;
        exp_flit = '0;
        exp_occ  = 0;
    endtask

    // One clock cycle: apply inputs, advance the reference, sample #1 after the edge.
    task automatic step(input logic wr, input logic [FW-1:0] d, input logic cin);
        bit pop;
        flit_in_wr = wr;
        flit_in    = d;
        credit_in  = cin;
        pop        = (mq.size() > 0) && (mcred > 0);
        exp_wr     = pop;
        exp_cout   = pop;
        if (pop) exp_flit = mq.pop_front();
        if (wr) begin
            if (mq.size() < B) mq.push_back(d);
            else exp_ovf = 1'b1;
        end
        if (pop && !cin) mcred--;
        else if (!pop && cin) begin
            if (mcred == B) exp_cerr = 1'b1;
            else mcred++;
        end
        exp_occ = mq.size();
        @(posedge clk);
        #1;
        flit_in_wr = 1'b0;
        credit_in  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({credit_out, flit_out_wr, ovf_err, credit_err} !== 4'b0 || flit_out !== '0 || occupancy !== '0) begin
            errors++;
            $display("FAIL reset_state: got cr=%b wr=%b flit=%h occ=%0d ovf=%b cerr=%b want all zero",
                     credit_out, flit_out_wr, flit_out, occupancy, ovf_err, credit_err);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int first = -1;
        int ncr = 0;
        logic [FW-1:0] seen[$];
        for (int i = 0; i < 10; i++) begin
            if (i < 4) step(1'b1, FW'(i + 1), 1'b0);
            else step(1'b0, '0, 1'b0);
            checks++;
            if (flit_out_wr !== exp_wr || credit_out !== exp_cout || flit_out !== exp_flit ||
                occupancy !== CNTW'(exp_occ) || ovf_err !== exp_ovf || credit_err !== exp_cerr) begin
                errors++;
                $display("FAIL basic c%0d: got wr=%b cr=%b flit=%h occ=%0d ovf=%b cerr=%b want wr=%b cr=%b flit=%h occ=%0d ovf=%b cerr=%b",
                         i, flit_out_wr, credit_out, flit_out, occupancy, ovf_err, credit_err,
                         exp_wr, exp_cout, exp_flit, exp_occ, exp_ovf, exp_cerr);
            end
            if (flit_out_wr === 1'b1) begin
                if (first < 0) first = i;
                seen.push_back(flit_out);
            end
            if (credit_out === 1'b1) ncr++;
        end
        checks++;
        if (first != 1) begin
            errors++;
            $display("FAIL basic_latency: first output after cycle %0d, want 1", first);
        end
        checks++;
        if (seen.size() != 4 || seen[0] !== FW'(1) || seen[1] !== FW'(2) || seen[2] !== FW'(3) || seen[3] !== FW'(4)) begin
            errors++;
            $display("FAIL basic_order: got %0d flits, want 4 flits 1..4", seen.size());
        end
        checks++;
        if (ncr != 4) begin
            errors++;
            $display("FAIL basic_credits: got %0d credit_out pulses want 4", ncr);
        end
    endtask

    task automatic test_no_credit();
        int nout = 0;
        int ncr = 0;
        logic [FW-1:0] last = '0;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) step(1'b1, FW'(i + 5), 1'b0);
            else step(1'b0, '0, 1'b0);
            checks++;
            if (flit_out_wr !== exp_wr || credit_out !== exp_cout || flit_out !== exp_flit ||
                occupancy !== CNTW'(exp_occ) || ovf_err !== exp_ovf || credit_err !== exp_cerr) begin
                errors++;
                $display("FAIL nocredit c%0d: got wr=%b cr=%b flit=%h occ=%0d want wr=%b cr=%b flit=%h occ=%0d",
                         i, flit_out_wr, credit_out, flit_out, occupancy, exp_wr, exp_cout, exp_flit, exp_occ);
            end
            if (flit_out_wr === 1'b1) nout++;
        end
        checks++;
        if (nout != 0 || occupancy !== CNTW'(4)) begin
            errors++;
            $display("FAIL nocredit_hold: got %0d outputs occ=%0d want 0 outputs occ=4", nout, occupancy);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, (i == 0));
            checks++;
            if (flit_out_wr !== exp_wr || credit_out !== exp_cout || flit_out !== exp_flit ||
                occupancy !== CNTW'(exp_occ) || ovf_err !== exp_ovf || credit_err !== exp_cerr) begin
                errors++;
                $display("FAIL onecredit c%0d: got wr=%b cr=%b flit=%h occ=%0d want wr=%b cr=%b flit=%h occ=%0d",
                         i, flit_out_wr, credit_out, flit_out, occupancy, exp_wr, exp_cout, exp_flit, exp_occ);
            end
            if (flit_out_wr === 1'b1) begin nout++; last = flit_out; end
            if (credit_out === 1'b1) ncr++;
        end
        checks++;
        if (nout != 1 || last !== FW'(5) || ncr != 1) begin
            errors++;
            $display("FAIL onecredit_total: got outs=%0d last=%h credits=%0d want outs=1 last=5 credits=1", nout, last, ncr);
        end
    endtask

    task automatic test_overflow();
        int nout = 0;
        bit saw9 = 1'b0;
        logic [FW-1:0] seen[$];
        // Top the buffer back up to full, then write 0x9 into it.
        step(1'b1, FW'('hC), 1'b0);
        step(1'b1, FW'('h9), 1'b0);
        checks++;
        if (ovf_err !== 1'b1 || occupancy !== CNTW'(4)) begin
            errors++;
            $display("FAIL overflow_flag: got ovf=%b occ=%0d want ovf=1 occ=4", ovf_err, occupancy);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, (i < 4));
            checks++;
            if (flit_out_wr !== exp_wr || credit_out !== exp_cout || flit_out !== exp_flit ||
                occupancy !== CNTW'(exp_occ) || ovf_err !== exp_ovf || credit_err !== exp_cerr) begin
                errors++;
                $display("FAIL overflow_drain c%0d: got wr=%b flit=%h occ=%0d ovf=%b want wr=%b flit=%h occ=%0d ovf=%b",
                         i, flit_out_wr, flit_out, occupancy, ovf_err, exp_wr, exp_flit, exp_occ, exp_ovf);
            end
            if (flit_out_wr === 1'b1) begin
                seen.push_back(flit_out);
                if (flit_out === FW'('h9)) saw9 = 1'b1;
            end
        end
        checks++;
        if (saw9 || seen.size() != 4 || seen[0] !== FW'(6) || seen[1] !== FW'(7) || seen[2] !== FW'(8) ||
            seen[3] !== FW'('hC) || occupancy !== '0) begin
            errors++;
            $display("FAIL overflow_order: got %0d flits saw9=%b occ=%0d want 6,7,8,C and occ=0",
                     seen.size(), saw9, occupancy);
        end
    endtask

    task automatic test_stream();
        logic [FW-1:0] sent[$];
        int first = -1;
        int last = -1;
        int nout = 0;
        int bad_order = 0;
        int max_occ = 0;
        logic [FW-1:0] d;
        for (int i = 0; i < 24; i++) begin
            d = FW'({$urandom(), $urandom()});
            if (i < 20) begin
                sent.push_back(d);
                step(1'b1, d, 1'b1);
            end else begin
                step(1'b0, '0, 1'b0);
            end
            checks++;
            if (flit_out_wr !== exp_wr || credit_out !== exp_cout || flit_out !== exp_flit ||
                occupancy !== CNTW'(exp_occ) || ovf_err !== exp_ovf || credit_err !== exp_cerr) begin
                errors++;
                $display("FAIL stream c%0d: got wr=%b cr=%b flit=%h occ=%0d want wr=%b cr=%b flit=%h occ=%0d",
                         i, flit_out_wr, credit_out, flit_out, occupancy, exp_wr, exp_cout, exp_flit, exp_occ);
            end
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
            if (flit_out_wr === 1'b1) begin
                if (first < 0) first = i;
                last = i;
                if (nout >= sent.size() || flit_out !== sent[nout]) bad_order++;
                nout++;
            end
        end
        checks++;
        if (nout != 20 || (last - first) != 19 || bad_order != 0) begin
            errors++;
            $display("FAIL stream_b2b: got outs=%0d span=%0d misordered=%0d want 20 outs span 19 in order",
                     nout, last - first, bad_order);
        end
        checks++;
        if (max_occ > 1) begin
            errors++;
            $display("FAIL stream_occ: got peak occupancy %0d want <= 1", max_occ);
        end
    endtask

    task automatic test_credit_err();
        int nout = 0;
        test_reset();
        step(1'b0, '0, 1'b1);
        checks++;
        if (credit_err !== 1'b1 || flit_out_wr !== 1'b0) begin
            errors++;
            $display("FAIL credit_err_flag: got cerr=%b wr=%b want cerr=1 wr=0", credit_err, flit_out_wr);
        end
        // Counter must still be exactly B: five flits, only four may leave.
        for (int i = 0; i < 10; i++) begin
            if (i < 5) step(1'b1, FW'(i + 'h20), 1'b0);
            else step(1'b0, '0, 1'b0);
            checks++;
            if (flit_out_wr !== exp_wr || credit_out !== exp_cout || flit_out !== exp_flit ||
                occupancy !== CNTW'(exp_occ) || ovf_err !== exp_ovf || credit_err !== exp_cerr) begin
                errors++;
                $display("FAIL credit_sat c%0d: got wr=%b flit=%h occ=%0d cerr=%b want wr=%b flit=%h occ=%0d cerr=%b",
                         i, flit_out_wr, flit_out, occupancy, credit_err, exp_wr, exp_flit, exp_occ, exp_cerr);
            end
            if (flit_out_wr === 1'b1) nout++;
        end
        checks++;
        if (nout != 4 || occupancy !== CNTW'(1)) begin
            errors++;
            $display("FAIL credit_sat_total: got outs=%0d occ=%0d want outs=4 occ=1", nout, occupancy);
        end
    endtask

    task automatic test_reset_midop();
        int nout = 0;
        int ncr = 0;
        logic [FW-1:0] last = '0;
        test_reset();
        for (int i = 0; i < 9; i++) begin
            if (i < 4 || i >= 6) step(1'b1, FW'(i + 'h40), 1'b0);
            else step(1'b0, '0, 1'b0);
        end
        checks++;
        if (occupancy !== CNTW'(3)) begin
            errors++;
            $display("FAIL midop_setup: got occ=%0d want 3", occupancy);
        end
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({credit_out, flit_out_wr, ovf_err, credit_err} !== 4'b0 || flit_out !== '0 || occupancy !== '0) begin
            errors++;
            $display("FAIL midop_reset: got cr=%b wr=%b flit=%h occ=%0d ovf=%b cerr=%b want all zero",
                     credit_out, flit_out_wr, flit_out, occupancy, ovf_err, credit_err);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) step(1'b1, FW'('hA), 1'b0);
            else step(1'b0, '0, 1'b0);
            checks++;
            if (flit_out_wr !== exp_wr || credit_out !== exp_cout || flit_out !== exp_flit ||
                occupancy !== CNTW'(exp_occ) || ovf_err !== exp_ovf || credit_err !== exp_cerr) begin
                errors++;
                $display("FAIL midop_after c%0d: got wr=%b cr=%b flit=%h occ=%0d want wr=%b cr=%b flit=%h occ=%0d",
                         i, flit_out_wr, credit_out, flit_out, occupancy, exp_wr, exp_cout, exp_flit, exp_occ);
            end
            if (flit_out_wr === 1'b1) begin nout++; last = flit_out; end
            if (credit_out === 1'b1) ncr++;
        end
        checks++;
        if (nout != 1 || last !== FW'('hA) || ncr != 1) begin
            errors++;
            $display("FAIL midop_stale: got outs=%0d last=%h credits=%0d want outs=1 last=a credits=1", nout, last, ncr);
        end
    endtask

    task automatic test_random();
        logic wr, cin;
        test_reset();
        for (int i = 0; i < 400; i++) begin
            wr  = ($urandom_range(0, 99) < 65);
            cin = ($urandom_range(0, 99) < 40);
            step(wr, FW'({$urandom(), $urandom()}), cin);
            checks++;
            if (flit_out_wr !== exp_wr || credit_out !== exp_cout || flit_out !== exp_flit ||
                occupancy !== CNTW'(exp_occ) || ovf_err !== exp_ovf || credit_err !== exp_cerr) begin
                errors++;
                $display("FAIL random c%0d: got wr=%b cr=%b flit=%h occ=%0d ovf=%b cerr=%b want wr=%b cr=%b flit=%h occ=%0d ovf=%b cerr=%b",
                         i, flit_out_wr, credit_out, flit_out, occupancy, ovf_err, credit_err,
                         exp_wr, exp_cout, exp_flit, exp_occ, exp_ovf, exp_cerr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_credit();
        test_overflow();
        test_stream();
        test_credit_err();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
